// File: rtl/rib_bridge.sv
// Data-memory bridge: arbitrates debug and core accesses onto one valid/ready slave bus.
// Optional RIB_TIMEOUT_EN aborts a stuck ADDR/DATA phase after TIMEOUT_CYCLES cycles.
module rib_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_rib_rreq_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic              mem_rib_wreq_i,
  input  logic              mem_wen_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              rib_hold_flag_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              s_valid_o,
  input  logic              s_ready_i,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_dbg_q, owner_dbg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              core_wr, core_req, abort;

  assign core_wr  = mem_rib_wreq_i & mem_wen_i;
  assign core_req = core_wr | mem_rib_rreq_i;

`ifdef RIB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy, err_q;

  assign busy  = (state_q == StAddr) || (state_q == StData);
  assign cnt_d = !busy ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // Abort in the cycle the count reaches the limit, unless the phase completes anyway.
  assign abort = busy && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) &&
                 !((state_q == StAddr) ? s_ready_i : s_rvalid_i);
  assign bus_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign bus_err_o      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_dbg_d = owner_dbg_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    mem_rdata_d = mem_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_req_i) begin
          state_d     = StAddr;
          owner_dbg_d = 1'b1;
          addr_d      = dbg_addr_i;
          we_d        = dbg_we_i;
          wdata_d     = dbg_wdata_i;
        end else if (core_wr) begin
          state_d     = StAddr;
          owner_dbg_d = 1'b0;
          addr_d      = mem_waddr_i;
          we_d        = 1'b1;
          wdata_d     = mem_wdata_i;
        end else if (mem_rib_rreq_i) begin
          state_d     = StAddr;
          owner_dbg_d = 1'b0;
          addr_d      = mem_raddr_i;
          we_d        = 1'b0;
          wdata_d     = '0;
        end
      end
      StAddr: begin
        if (s_ready_i) state_d = we_q ? StDone : StData;
      end
      StData: begin
        if (s_rvalid_i) begin
          state_d = StDone;
          if (owner_dbg_q) dbg_rdata_d = s_rdata_i;
          else             mem_rdata_d = s_rdata_i;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StDone;
      if (!we_q) begin
        if (owner_dbg_q) dbg_rdata_d = '0;
        else             mem_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      owner_dbg_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_dbg_q <= owner_dbg_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      mem_rdata_q <= mem_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign s_valid_o   = (state_q == StAddr);
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_wdata_o   = wdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign dbg_ack_o   = (state_q == StDone) && owner_dbg_q;

  // Gated by reset so the stall is released the moment reset is applied.
  assign rib_hold_flag_o = rst_n_i &&
      ((core_req && !((state_q == StDone) && !owner_dbg_q)) ||
       ((state_q != StIdle) && owner_dbg_q) ||
       (dbg_req_i && (state_q == StIdle)));

endmodule

// File: tb/tb_rib_bridge.sv
// Self-checking bench for rib_bridge: directed scenarios plus randomized transactions
// checked against a per-transaction reference of cycle counts, hold level and returned data.
module tb_rib_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          mem_rib_rreq_i, mem_rib_wreq_i, mem_wen_i;
  logic [AW-1:0] mem_raddr_i, mem_waddr_i;
  logic [DW-1:0] mem_wdata_i, mem_rdata_o;
  logic          rib_hold_flag_o;
  logic          dbg_req_i, dbg_we_i, dbg_ack_o;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i, dbg_rdata_o;
  logic          s_valid_o, s_ready_i, s_we_o, s_rvalid_i, bus_err_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o, s_rdata_i;

  always #5 clk_i = ~clk_i;

  rib_bridge #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .mem_rib_rreq_i  (mem_rib_rreq_i),
    .mem_raddr_i     (mem_raddr_i),
    .mem_rib_wreq_i  (mem_rib_wreq_i),
    .mem_wen_i       (mem_wen_i),
    .mem_waddr_i     (mem_waddr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_rdata_o     (mem_rdata_o),
    .rib_hold_flag_o (rib_hold_flag_o),
    .dbg_req_i       (dbg_req_i),
    .dbg_we_i        (dbg_we_i),
    .dbg_addr_i      (dbg_addr_i),
    .dbg_wdata_i     (dbg_wdata_i),
    .dbg_rdata_o     (dbg_rdata_o),
    .dbg_ack_o       (dbg_ack_o),
    .s_valid_o       (s_valid_o),
    .s_ready_i       (s_ready_i),
    .s_we_o          (s_we_o),
    .s_addr_o        (s_addr_o),
    .s_wdata_o       (s_wdata_o),
    .s_rvalid_i      (s_rvalid_i),
    .s_rdata_i       (s_rdata_i),
    .bus_err_o       (bus_err_o)
  );

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_mem, exp_dbg;  // model of last data returned to each owner

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic to_pos();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk_i);
    chk({tag, "_valid"}, s_valid_o, 0);
    chk({tag, "_hold"}, rib_hold_flag_o, 0);
    chk({tag, "_ack"}, dbg_ack_o, 0);
    to_pos();
  endtask

  // Caller has driven the winning request in an IDLE cycle. rd/vd are slave wait states.
  task automatic do_txn(input bit dbg, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rdat,
                        input int rd, input int vd, input bit raise_dbg);
    @(negedge clk_i);
    chk("idle_valid", s_valid_o, 0);
    chk("idle_hold", rib_hold_flag_o, 1);
    to_pos();
    for (int i = 0; i <= rd; i++) begin
      if (raise_dbg && i == 0) dbg_req_i = 1'b1;
      s_ready_i  = (i == rd);
      s_rvalid_i = 1'($urandom_range(0, 1));  // stray rvalid outside DATA must be ignored
      s_rdata_i  = $urandom;
      @(negedge clk_i);
      chk("addr_valid", s_valid_o, 1);
      chk("addr_addr", s_addr_o, a);
      chk("addr_we", s_we_o, we);
      if (we) chk("addr_wdata", s_wdata_o, wd);
      chk("addr_hold", rib_hold_flag_o, 1);
      chk("addr_ack", dbg_ack_o, 0);
      to_pos();
    end
    s_ready_i = 1'b0;
    if (!we) begin
      for (int i = 0; i <= vd; i++) begin
        s_rvalid_i = (i == vd);
        s_rdata_i  = (i == vd) ? rdat : $urandom;
        @(negedge clk_i);
        chk("data_valid", s_valid_o, 0);
        chk("data_hold", rib_hold_flag_o, 1);
        to_pos();
      end
      if (dbg) exp_dbg = rdat;
      else     exp_mem = rdat;
    end
    s_rvalid_i = 1'($urandom_range(0, 1));
    s_rdata_i  = $urandom;
    @(negedge clk_i);
    chk("done_valid", s_valid_o, 0);
    chk("done_hold", rib_hold_flag_o, dbg ? 1 : 0);
    chk("done_ack", dbg_ack_o, dbg);
    chk("done_mem_rdata", mem_rdata_o, exp_mem);
    chk("done_dbg_rdata", dbg_rdata_o, exp_dbg);
    chk("done_bus_err", bus_err_o, 0);
    if (dbg) dbg_req_i = 1'b0;
    else begin
      mem_rib_rreq_i = 1'b0;
      mem_rib_wreq_i = 1'b0;
      mem_wen_i      = 1'b0;
    end
    s_rvalid_i = 1'b0;
    to_pos();
  endtask

  int            kind, rd, vd;
  logic [AW-1:0] a, a2;
  logic [DW-1:0] d, r, r2;

  initial begin
    rst_n_i = 1'b0;
    {mem_rib_rreq_i, mem_rib_wreq_i, mem_wen_i, dbg_req_i, dbg_we_i} = '0;
    {mem_raddr_i, mem_waddr_i, mem_wdata_i, dbg_addr_i, dbg_wdata_i} = '0;
    {s_ready_i, s_rvalid_i, s_rdata_i} = '0;
    exp_mem = '0;
    exp_dbg = '0;
    #2;
    chk("rst_valid", s_valid_o, 0);
    chk("rst_hold", rib_hold_flag_o, 0);
    chk("rst_ack", dbg_ack_o, 0);
    chk("rst_mem_rdata", mem_rdata_o, 0);
    chk("rst_dbg_rdata", dbg_rdata_o, 0);
    chk("rst_addr", s_addr_o, 0);
    chk("rst_we", s_we_o, 0);
    chk("rst_wdata", s_wdata_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    #10 rst_n_i = 1'b1;
    to_pos();

    // Zero-wait core read
    mem_rib_rreq_i = 1'b1;
    mem_raddr_i    = 32'h1000;
    do_txn(0, 0, 32'h1000, '0, 32'hDEADBEEF, 0, 0, 0);
    idle_check("t1_after");

    // Core write with four ready wait states
    mem_rib_wreq_i = 1'b1;
    mem_wen_i      = 1'b1;
    mem_waddr_i    = 32'h2004;
    mem_wdata_i    = 32'h12345678;
    do_txn(0, 1, 32'h2004, 32'h12345678, '0, 4, 0, 0);
    idle_check("t2_after");

    // Debug read races a core read; debug first, then the core
    dbg_req_i      = 1'b1;
    dbg_we_i       = 1'b0;
    dbg_addr_i     = '0;
    mem_rib_rreq_i = 1'b1;
    mem_raddr_i    = 32'h3000;
    do_txn(1, 0, '0, '0, 32'hCAFEF00D, 0, 0, 0);
    do_txn(0, 0, 32'h3000, '0, 32'h0BADC0DE, 0, 1, 0);
    idle_check("t3_after");

    // Write request without write enable is not a request
    mem_rib_wreq_i = 1'b1;
    mem_wen_i      = 1'b0;
    mem_waddr_i    = 32'h4000;
    idle_check("t4_a");
    idle_check("t4_b");
    idle_check("t4_c");
    mem_rib_wreq_i = 1'b0;

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 6);
      rd   = $urandom_range(0, 3);
      vd   = $urandom_range(0, 3);
      a    = $urandom;
      a2   = $urandom;
      d    = $urandom;
      r    = $urandom;
      r2   = $urandom;
      case (kind)
        0: begin
          mem_rib_rreq_i = 1'b1;
          mem_raddr_i    = a;
          do_txn(0, 0, a, d, r, rd, vd, 0);
        end
        1, 4: begin
          // kind 4 adds a simultaneous read that must be dropped
          mem_rib_rreq_i = (kind == 4);
          mem_raddr_i    = a2;
          mem_rib_wreq_i = 1'b1;
          mem_wen_i      = 1'b1;
          mem_waddr_i    = a;
          mem_wdata_i    = d;
          do_txn(0, 1, a, d, r, rd, vd, 0);
        end
        2, 3: begin
          dbg_req_i   = 1'b1;
          dbg_we_i    = (kind == 3);
          dbg_addr_i  = a;
          dbg_wdata_i = d;
          do_txn(1, kind == 3, a, d, r, rd, vd, 0);
        end
        5: begin
          dbg_req_i      = 1'b1;
          dbg_we_i       = 1'b0;
          dbg_addr_i     = a;
          mem_rib_rreq_i = 1'b1;
          mem_raddr_i    = a2;
          do_txn(1, 0, a, d, r, rd, vd, 0);
          do_txn(0, 0, a2, d, r2, vd, rd, 0);
        end
        default: begin
          // Debug arrives mid core transaction and waits for IDLE
          mem_rib_rreq_i = 1'b1;
          mem_raddr_i    = a;
          dbg_we_i       = 1'b1;
          dbg_addr_i     = a2;
          dbg_wdata_i    = d;
          do_txn(0, 0, a, d, r, rd, vd, 1);
          do_txn(1, 1, a2, d, r2, vd, rd, 0);
        end
      endcase
      idle_check("rand_after");
    end

    // Slave never ready on a core read
    mem_rib_rreq_i = 1'b1;
    mem_raddr_i    = 32'h5000;
    to_pos();
`ifdef RIB_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk_i);
      chk("to_valid", s_valid_o, 1);
      chk("to_err_early", bus_err_o, 0);
      to_pos();
    end
    @(negedge clk_i);
    exp_mem = '0;
    chk("to_done_valid", s_valid_o, 0);
    chk("to_bus_err", bus_err_o, 1);
    chk("to_mem_rdata", mem_rdata_o, exp_mem);
    chk("to_hold", rib_hold_flag_o, 0);
    mem_rib_rreq_i = 1'b0;
    to_pos();
    chk("to_err_pulse", bus_err_o, 0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("stall_valid", s_valid_o, 1);
      chk("stall_hold", rib_hold_flag_o, 1);
      chk("stall_bus_err", bus_err_o, 0);
      to_pos();
    end
    s_ready_i = 1'b1;
    to_pos();
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hA5A5_5A5A;
    to_pos();
    s_rvalid_i = 1'b0;
    exp_mem    = 32'hA5A5_5A5A;
    @(negedge clk_i);
    chk("stall_done_mem", mem_rdata_o, exp_mem);
    chk("stall_done_hold", rib_hold_flag_o, 0);
    mem_rib_rreq_i = 1'b0;
    to_pos();
`endif
    idle_check("to_after");

    // Reset while in DATA
    mem_rib_rreq_i = 1'b1;
    mem_raddr_i    = 32'h6004;
    to_pos();
    s_ready_i = 1'b1;
    to_pos();
    s_ready_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", s_valid_o, 0);
    chk("mid_rst_hold", rib_hold_flag_o, 0);
    chk("mid_rst_addr", s_addr_o, 0);
    chk("mid_rst_mem", mem_rdata_o, 0);
    chk("mid_rst_dbg", dbg_rdata_o, 0);
    chk("mid_rst_ack", dbg_ack_o, 0);
    exp_mem        = '0;
    exp_dbg        = '0;
    mem_rib_rreq_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    to_pos();
    idle_check("post_rst");
    dbg_req_i  = 1'b1;
    dbg_we_i   = 1'b0;
    dbg_addr_i = 32'h7000;
    do_txn(1, 0, 32'h7000, '0, 32'h1357_9BDF, 1, 2, 0);
    idle_check("post_rst_txn");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
